// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS layout and transmit FSM encoding.
package uart_pkg;

  localparam logic [1:0] UART_TXDATA  = 2'd0;
  localparam logic [1:0] UART_STATUS  = 2'd1;
  localparam logic [1:0] UART_DIVISOR = 2'd2;
  localparam logic [1:0] UART_CTRL    = 2'd3;

  localparam int unsigned STAT_BUSY      = 32'd0;
  localparam int unsigned STAT_FULL      = 32'd1;
  localparam int unsigned STAT_EMPTY     = 32'd2;
  localparam int unsigned STAT_OVF       = 32'd3;
  localparam int unsigned STAT_COUNT_LSB = 32'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  function automatic logic [31:0] pack_status(input logic       busy,
                                              input logic       full,
                                              input logic       empty,
                                              input logic       ovf,
                                              input logic [7:0] count);
    logic [31:0] word;
    word                        = 32'd0;
    word[STAT_BUSY]             = busy;
    word[STAT_FULL]             = full;
    word[STAT_EMPTY]            = empty;
    word[STAT_OVF]              = ovf;
    word[STAT_COUNT_LSB +: 8]   = count;
    return word;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; the head entry is always visible
// on rdata. A push into a full FIFO is accepted only when a pop frees a slot.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = 32'd8,
  parameter int unsigned DEPTH = 32'd8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // flag and handshake decode from the pointer pair
  always_comb begin
    empty     = (wr_ptr_r == rd_ptr_r);
    full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    count     = wr_ptr_r - rd_ptr_r;
    rdata     = mem_r[rd_ptr_r[AW-1:0]];
    pop_ok_s  = pop && !empty;
    push_ok_s = push && (!full || pop_ok_s);
  end

  // storage array, contents need no reset
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wdata;
    end
  end

  // read/write pointers
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register decode, byte FIFO, divisor
// timing and the START/DATA/STOP serialiser.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH     = 32'd8,
  parameter logic [15:0] DIV_RESET = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [3:0]  we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq
);

  localparam int unsigned CW = $clog2(DEPTH) + 32'd1;

  tx_state_e   state_r, next_state_s;
  logic [15:0] divisor_r, div_lat_r, cnt_r;
  logic [7:0]  shift_r;
  logic [2:0]  bit_idx_r;
  logic        overflow_r, irq_en_r, tx_r, irq_r;
  logic [31:0] rdata_r, rd_word_s;
  logic        wr_txdata_s, rd_s, ovf_set_s, ovf_clr_s;
  logic        pop_s, bit_done_s, tx_s, busy_s, irq_s;
  logic [7:0]  fifo_head_s;
  logic        fifo_full_s, fifo_empty_s;
  logic [CW-1:0] fifo_count_s;
  logic        unused_s;

  assign unused_s = ^wdata[31:16];
  assign rdata    = rdata_r;
  assign tx       = tx_r;
  assign irq      = irq_r;

  sync_fifo #(.WIDTH(32'd8), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_txdata_s),
    .pop   (pop_s),
    .wdata (wdata[7:0]),
    .rdata (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // bus decode; a push that loses against a full FIFO raises overflow
  always_comb begin
    wr_txdata_s = sel && we[0] && (addr == UART_TXDATA);
    rd_s        = sel && (we == 4'b0000);
    ovf_set_s   = wr_txdata_s && fifo_full_s && !pop_s;
    ovf_clr_s   = sel && we[0] && (addr == UART_STATUS) && wdata[STAT_OVF];
    case (addr)
      UART_TXDATA:  rd_word_s = 32'd0;
      UART_STATUS:  rd_word_s = pack_status(busy_s, fifo_full_s, fifo_empty_s,
                                            overflow_r, 8'(fifo_count_s));
      UART_DIVISOR: rd_word_s = {16'd0, divisor_r};
      UART_CTRL:    rd_word_s = {31'd0, irq_en_r};
      default:      rd_word_s = 32'd0;
    endcase
  end

  // software-visible registers; overflow set takes priority over its clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      divisor_r  <= DIV_RESET;
      irq_en_r   <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (sel && we[0] && (addr == UART_DIVISOR)) divisor_r[7:0]  <= wdata[7:0];
      if (sel && we[1] && (addr == UART_DIVISOR)) divisor_r[15:8] <= wdata[15:8];
      if (sel && we[0] && (addr == UART_CTRL))    irq_en_r        <= wdata[0];
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (ovf_clr_s) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next state; the end of STOP chains straight into the next START
  always_comb begin
    next_state_s = state_r;
    pop_s        = 1'b0;
    bit_done_s   = (cnt_r == 16'd0);
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          next_state_s = ST_START;
          pop_s        = 1'b1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_done_s) next_state_s = ST_DATA;
        else            next_state_s = ST_START;
      end
      ST_DATA: begin
        if (bit_done_s && (bit_idx_r == 3'd7)) next_state_s = ST_STOP;
        else                                   next_state_s = ST_DATA;
      end
      ST_STOP: begin
        if (bit_done_s) begin
          if (!fifo_empty_s) begin
            next_state_s = ST_START;
            pop_s        = 1'b1;
          end else begin
            next_state_s = ST_IDLE;
          end
        end else begin
          next_state_s = ST_STOP;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // FSM outputs, registered below
  always_comb begin
    case (state_r)
      ST_IDLE:  tx_s = 1'b1;
      ST_START: tx_s = 1'b0;
      ST_DATA:  tx_s = shift_r[0];
      ST_STOP:  tx_s = 1'b1;
      default:  tx_s = 1'b1;
    endcase
    busy_s = (state_r != ST_IDLE);
    irq_s  = irq_en_r && fifo_empty_s && !busy_s;
  end

  // bit timing and shifter; divisor is sampled only when a byte is popped
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r     <= 16'd0;
      div_lat_r <= DIV_RESET;
      shift_r   <= 8'd0;
      bit_idx_r <= 3'd0;
    end else if (pop_s) begin
      cnt_r     <= divisor_r;
      div_lat_r <= divisor_r;
      shift_r   <= fifo_head_s;
      bit_idx_r <= 3'd0;
    end else if (busy_s && bit_done_s) begin
      cnt_r <= div_lat_r;
      if (state_r == ST_DATA) begin
        shift_r   <= {1'b0, shift_r[7:1]};
        bit_idx_r <= bit_idx_r + 3'd1;
      end
    end else if (busy_s) begin
      cnt_r <= cnt_r - 16'd1;
    end
  end

  // registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_r    <= 1'b1;
      irq_r   <= 1'b0;
      rdata_r <= 32'd0;
    end else begin
      tx_r  <= tx_s;
      irq_r <= irq_s;
      if (rd_s) begin
        rdata_r <= rd_word_s;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a serial monitor decodes frames on tx and
// checks them against a queue of bytes expected to go out.
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sel = 1'b0;
  logic [3:0]  we = 4'd0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        tx;
  logic        irq;

  uart_tx #(.DEPTH(32'd8), .DIV_RESET(16'd434)) dut (
    .clk(clk), .reset(reset), .sel(sel), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [7:0] sb[$];
  int  cur_p = 435;
  bit  mon_busy = 1'b0;
  bit  check_gap = 1'b0;
  bit  have_prev = 1'b0;
  int  prev_start = 0;
  logic [7:0] mon_byte;
  logic [7:0] mon_exp;
  logic mon_stop;
  bit  mon_abort;
  int  mon_p;
  int  mon_start;

  always @(posedge clk) cyc <= cyc + 1;

  // serial monitor: samples the first cycle of every bit of a frame
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && tx === 1'b0) begin
        mon_busy  = 1'b1;
        mon_p     = cur_p;
        mon_start = cyc;
        mon_abort = 1'b0;
        mon_byte  = 8'd0;
        mon_stop  = 1'b0;
        if (check_gap) begin
          if (have_prev) begin
            n_cmp++;
            if (mon_start - prev_start !== 10 * mon_p) begin
              n_bad++;
              $display("FAIL frame_spacing: got %0d cycles, expected %0d", mon_start - prev_start, 10 * mon_p);
            end
          end
          prev_start = mon_start;
          have_prev  = 1'b1;
        end
        for (int k = 0; k < 9; k++) begin
          repeat (mon_p) @(negedge clk);
          if (reset !== 1'b1) mon_abort = 1'b1;
          else if (k < 8) mon_byte[k] = tx;
          else mon_stop = tx;
        end
        if (!mon_abort) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL frame_unexpected: got byte %02h, expected no frame", mon_byte);
          end else begin
            mon_exp = sb.pop_front();
            if (mon_byte !== mon_exp) begin
              n_bad++;
              $display("FAIL frame_byte: got %02h, expected %02h", mon_byte, mon_exp);
            end
          end
          n_cmp++;
          if (mon_stop !== 1'b1) begin
            n_bad++;
            $display("FAIL stop_bit: got %b, expected 1", mon_stop);
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] w);
    @(negedge clk);
    sel = 1'b1; addr = a; wdata = d; we = w;
    @(negedge clk);
    sel = 1'b0; we = 4'd0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; addr = a; we = 4'd0;
    @(negedge clk);
    sel = 1'b0;
    d = rdata;
  endtask

  // consecutive-cycle TXDATA writes; only the first n_keep are expected on tx
  task automatic write_burst(input int n, input int n_keep, input int seed);
    logic [7:0] b;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      b = 8'(seed + i * 37);
      sel = 1'b1; we = 4'b0001; addr = 2'd0; wdata = {24'd0, b};
      if (i < n_keep) sb.push_back(b);
      @(negedge clk);
    end
    sel = 1'b0; we = 4'd0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && (sb.size() != 0 || mon_busy); i++) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0 || mon_busy) begin
      n_bad++;
      $display("FAIL drain: got %0d bytes pending, expected 0", sb.size());
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if (tx !== 1'b1)     begin n_bad++; $display("FAIL reset_tx: got %b, expected 1", tx); end
    n_cmp++; if (irq !== 1'b0)    begin n_bad++; $display("FAIL reset_irq: got %b, expected 0", irq); end
    n_cmp++; if (rdata !== 32'd0) begin n_bad++; $display("FAIL reset_rdata: got %h, expected 0", rdata); end
    reset = 1'b1;
    bus_read(2'd1, d);
    n_cmp++; if (d !== 32'h4)     begin n_bad++; $display("FAIL reset_status: got %h, expected 00000004", d); end
    bus_read(2'd2, d);
    n_cmp++; if (d !== 32'd434)   begin n_bad++; $display("FAIL reset_divisor: got %0d, expected 434", d); end
    bus_read(2'd3, d);
    n_cmp++; if (d !== 32'd0)     begin n_bad++; $display("FAIL reset_ctrl: got %h, expected 0", d); end
  endtask

  task automatic test_single_frame();
    logic [31:0] d;
    bus_write(2'd2, 32'd3, 4'b0011);
    cur_p = 4;
    sb.push_back(8'hA5);
    bus_write(2'd0, 32'hFFFF_FFA5, 4'b0001);
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL start_lat0: got %b, expected 1", tx); end
    @(negedge clk);
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL start_lat1: got %b, expected 1", tx); end
    @(negedge clk);
    n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL start_lat2: got %b, expected 0", tx); end
    bus_read(2'd1, d);
    n_cmp++; if (d !== 32'h5) begin n_bad++; $display("FAIL busy_status: got %h, expected 00000005", d); end
    bus_read(2'd0, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL txdata_read: got %h, expected 0", d); end
    wait_drain(200);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    bus_write(2'd2, 32'd0, 4'b0011);
    cur_p = 1;
    have_prev = 1'b0;
    check_gap = 1'b1;
    write_burst(9, 9, 3);
    wait_drain(300);
    check_gap = 1'b0;
    bus_read(2'd1, d);
    n_cmp++; if (d !== 32'h4) begin n_bad++; $display("FAIL b2b_status: got %h, expected 00000004", d); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    bus_write(2'd2, 32'd1000, 4'b0011);
    cur_p = 1001;
    write_burst(10, 9, 91);
    bus_read(2'd1, d);
    n_cmp++; if (d !== 32'h80B) begin n_bad++; $display("FAIL ovf_status: got %h, expected 0000080b", d); end
    bus_write(2'd1, 32'h7, 4'b0001);
    bus_read(2'd1, d);
    n_cmp++; if (d !== 32'h80B) begin n_bad++; $display("FAIL ovf_noclear: got %h, expected 0000080b", d); end
    bus_write(2'd1, 32'h8, 4'b0001);
    bus_read(2'd1, d);
    n_cmp++; if (d !== 32'h803) begin n_bad++; $display("FAIL ovf_clear: got %h, expected 00000803", d); end
    bus_write(2'd2, 32'd0, 4'b0011);
    cur_p = 1;
    wait_drain(11000);
  endtask

  task automatic test_irq();
    logic [31:0] d;
    bus_write(2'd2, 32'd3, 4'b0011);
    cur_p = 4;
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_disabled: got %b, expected 0", irq); end
    bus_write(2'd3, 32'd1, 4'b0001);
    @(negedge clk);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_idle: got %b, expected 1", irq); end
    sb.push_back(8'h3C);
    bus_write(2'd0, 32'h3C, 4'b0001);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_hold: got %b, expected 1", irq); end
    @(negedge clk);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_fall: got %b, expected 0", irq); end
    repeat (40) @(negedge clk);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_early: got %b, expected 0", irq); end
    @(negedge clk);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_rise: got %b, expected 1", irq); end
    wait_drain(100);
    bus_read(2'd3, d);
    n_cmp++; if (d !== 32'd1) begin n_bad++; $display("FAIL ctrl_read: got %h, expected 1", d); end
    bus_write(2'd3, 32'd0, 4'b0001);
    @(negedge clk);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_off: got %b, expected 0", irq); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d;
    int lows;
    bus_write(2'd0, 32'h5A, 4'b0001);
    repeat (14) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL midreset_tx: got %b, expected 1", tx); end
    repeat (5) @(negedge clk);
    reset = 1'b1;
    bus_read(2'd1, d);
    n_cmp++; if (d !== 32'h4)   begin n_bad++; $display("FAIL midreset_status: got %h, expected 00000004", d); end
    bus_read(2'd2, d);
    n_cmp++; if (d !== 32'd434) begin n_bad++; $display("FAIL midreset_divisor: got %0d, expected 434", d); end
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    n_cmp++; if (lows !== 0) begin n_bad++; $display("FAIL midreset_residual: got %0d low cycles, expected 0", lows); end
    wait_drain(100);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_irq();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
